nvdla_cdma_wt_rd_issue: RTL and testbench
=========================================

# nvdla_cdma_wt_rd_issue

Requester-side issue stage for the CDMA weight-read strict-priority arbiter. It presents two weight-fetch sources (src0 high priority, src1 low priority) as arbiter requests and consumes the one-hot grant. It drives the arbiter's `gnt_busy` back-pressure, captures the granted payload into a registered DMA read-request port, and caps outstanding DMA reads with a credit counter. It sits between the weight-fetch sequencers and the CDMA DMA read interface.

## Interface
- `PD_W`, 79, request payload width (address + size).
- `MAX_OUTS`, 8, maximum outstanding DMA reads (1..255).
- `CRD_W`, 4, credit counter width; must satisfy `2**CRD_W > MAX_OUTS`.

- `nvdla_core_clk`  in  1  core clock; all state on rising edge.
- `nvdla_core_rstn`  in  1  asynchronous, active-low reset.
- `cfg_en`  in  1  issue enable; low forces busy.
- `src0_req_valid` / `src1_req_valid`  in  1  source request pending.
- `src0_req_pd` / `src1_req_pd`  in  PD_W  source payload; stable while valid.
- `src0_req_ack` / `src1_req_ack`  out  1  single-cycle accept pulse.
- `arb_req0` / `arb_req1`  out  1  to arbiter req0/req1.
- `arb_gnt0` / `arb_gnt1`  in  1  from arbiter; already masked by busy.
- `arb_gnt_busy`  out  1  to arbiter `gnt_busy`.
- `dma_rd_req_valid`  out  1  DMA request valid.
- `dma_rd_req_ready`  in  1  DMA request ready.
- `dma_rd_req_pd`  out  PD_W  DMA request payload.
- `dma_rd_req_src`  out  1  source ID of the request (0/1).
- `dma_rd_rsp_done`  in  1  one pulse per completed DMA read; returns one credit.
- `credit_err`  out  1  sticky flag: credit returned while the counter was full.
- `dbg_stall_cnt`  out  32  stall counter (see Configuration).

## Operation
- `arb_reqN = srcN_req_valid`; purely combinational, no dependence on grant.
- `out_full = dma_rd_req_valid & !dma_rd_req_ready`.
- `arb_gnt_busy = !cfg_en | out_full | (credit == 0)`.
- Combinational path from `dma_rd_req_ready` to `arb_gnt_busy` is required for full throughput. No loop exists because `arb_req` does not depend on busy.
- Accept occurs when `arb_gnt0 | arb_gnt1` is high. `srcN_req_ack = arb_gntN`. The accepted payload and source ID load into the output register.
- Output register has two states:
  - EMPTY: `dma_rd_req_valid` is 0. Goes to FULL on accept.
  - FULL: `dma_rd_req_valid` is 1. On a ready handshake it stays FULL if an accept happens in the same cycle (back-to-back load), and goes to EMPTY otherwise.
  - Payload and `src` hold unchanged while FULL and not ready.
- Credit counter:
  - Resets to `MAX_OUTS`.
  - Decrements on accept and increments on `dma_rd_rsp_done`. Both in one cycle leaves it unchanged.
  - When `credit == 0`, busy is asserted, so no accept can occur.
  - `dma_rd_rsp_done` at `credit == MAX_OUTS` leaves the count unchanged and sets `credit_err` until reset.
- Both grants high in one cycle is illegal: there is no accept, and simulation raises an assertion.
- Dropping `cfg_en` mid-operation blocks new accepts only. A FULL register still drains, and credits still return.

## Timing
- Reset values:
  - `dma_rd_req_valid`, `dma_rd_req_pd`, `dma_rd_req_src`, `credit_err`, `dbg_stall_cnt`: 0.
  - credit: `MAX_OUTS`.
  - `src*_req_ack`, `arb_req*`, `arb_gnt_busy`: follow their combinational equations from reset state.
- Latency: an accept in cycle T gives `dma_rd_req_valid` = 1 at T+1.
- Throughput: one request per cycle while `dma_rd_req_ready` = 1 and credits are available.
- A source must deassert valid, or present its next payload, in the cycle after its ack.
- DMA valid/ready: valid never drops without a handshake, and the payload is stable while valid is high.

## Configuration
- `NVDLA_CDMA_WT_ISSUE_STALL_CNT_EN` defined:
  - `dbg_stall_cnt` increments each cycle with `(src0_req_valid | src1_req_valid) & arb_gnt_busy`.
  - Saturates at `32'hFFFFFFFF`.
  - Cleared only by reset.
- Undefined: `dbg_stall_cnt` is tied to 0 and no counter flops exist. The port is always present.

## Structure
- Shared package `nvdla_cdma_wt_pkg` holds:
  - `PD_W` and `MAX_OUTS` defaults.
  - Source-ID constants `WT_SRC0 = 1'b0`, `WT_SRC1 = 1'b1`.
  - A payload typedef.
- One sub-module, `nvdla_cdma_wt_credit_cnt`. It handles the credit counter: inc/dec, zero flag, and overflow to `credit_err`.
- The output register and busy logic stay in the top module.

## Test plan
- Reset released, src0 only valid, ready=1, `pd=0x1000` -> ack0 pulses at T, `dma_rd_req_valid`=1 with `pd=0x1000` and `src=0` at T+1, credit goes 8→7.
- src0 and src1 valid together for 3 cycles -> three src0 acks, no src1 ack. src1 is acked in the cycle src0 drops.
- `dma_rd_req_ready`=0 for 4 cycles while FULL -> `arb_gnt_busy`=1, no acks, payload stable. Ready=1 -> handshake and a new accept in the same cycle.
- 8 accepts with no `rsp_done` -> credit=0, busy=1. `rsp_done` pulse -> the next accept occurs the following cycle. Simultaneous accept + `rsp_done` -> credit unchanged.
- `rsp_done` at credit=8 -> `credit_err`=1 and stays 1. `cfg_en` dropped while FULL -> the register drains, then no further acks.
- Macro defined: src1 valid with ready=0 for 10 cycles -> `dbg_stall_cnt`=10. Macro undefined: stays 0.

Source files
------------

// File: rtl/nvdla_cdma_wt_pkg.sv
// nvdla_cdma_wt_pkg: shared defaults, source IDs and types for the CDMA weight-read issue stage.
package nvdla_cdma_wt_pkg;
   localparam int PD_W_DEF     = 79;
   localparam int MAX_OUTS_DEF = 8;
   localparam int CRD_W_DEF    = 4;
   localparam logic WT_SRC0 = 1'b0;
   localparam logic WT_SRC1 = 1'b1;
   typedef logic [PD_W_DEF-1:0] wt_pd_t;
   typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} wt_out_state_e;
endpackage

// File: rtl/nvdla_cdma_wt_credit_cnt.sv
// nvdla_cdma_wt_credit_cnt: outstanding-read credit counter.
// Ports: nvdla_core_clk/nvdla_core_rstn clock and async active-low reset;
// dec_i consumes a credit (accept), inc_i returns one (rsp done);
// zero_o flags no credit left; credit_err_o is sticky on a return while full.
module nvdla_cdma_wt_credit_cnt #(
   parameter int MAX_OUTS = 8,
   parameter int CRD_W    = 4
) (
   input  logic nvdla_core_clk,
   input  logic nvdla_core_rstn,
   input  logic inc_i,
   input  logic dec_i,
   output logic zero_o,
   output logic credit_err_o
);
   localparam logic [CRD_W-1:0] MAX_C = CRD_W'(MAX_OUTS);
   logic [CRD_W-1:0] credit_q, credit_d;
   logic             err_q, err_d;
   logic             full;
   assign full = credit_q == MAX_C;
   // a return at full is dropped so the count never exceeds MAX_OUTS
   assign credit_d = (dec_i & ~inc_i) ? credit_q - CRD_W'(1) :
                     (inc_i & ~dec_i & ~full) ? credit_q + CRD_W'(1) : credit_q;
   assign err_d = err_q | (inc_i & full);
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         credit_q <= MAX_C;
         err_q    <= 1'b0;
      end else begin
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end
   assign zero_o       = credit_q == '0;
   assign credit_err_o = err_q;
endmodule

// File: rtl/nvdla_cdma_wt_rd_issue.sv
// nvdla_cdma_wt_rd_issue: requester-side issue stage for the CDMA weight-read priority arbiter.
// Ports: src0/src1 request valid/pd in, ack out; arb_req0/1 out, arb_gnt0/1 in,
// arb_gnt_busy out; registered DMA read request (valid/ready/pd/src);
// dma_rd_rsp_done returns credits; credit_err sticky; dbg_stall_cnt debug counter.
// Optional stall counter enabled by NVDLA_CDMA_WT_ISSUE_STALL_CNT_EN.
module nvdla_cdma_wt_rd_issue
   import nvdla_cdma_wt_pkg::*;
#(
   parameter int PD_W     = PD_W_DEF,
   parameter int MAX_OUTS = MAX_OUTS_DEF,
   parameter int CRD_W    = CRD_W_DEF
) (
   input  logic            nvdla_core_clk,
   input  logic            nvdla_core_rstn,
   input  logic            cfg_en,
   input  logic            src0_req_valid,
   input  logic [PD_W-1:0] src0_req_pd,
   output logic            src0_req_ack,
   input  logic            src1_req_valid,
   input  logic [PD_W-1:0] src1_req_pd,
   output logic            src1_req_ack,
   output logic            arb_req0,
   output logic            arb_req1,
   input  logic            arb_gnt0,
   input  logic            arb_gnt1,
   output logic            arb_gnt_busy,
   output logic            dma_rd_req_valid,
   input  logic            dma_rd_req_ready,
   output logic [PD_W-1:0] dma_rd_req_pd,
   output logic            dma_rd_req_src,
   input  logic            dma_rd_rsp_done,
   output logic            credit_err,
   output logic [31:0]     dbg_stall_cnt
);
   wt_out_state_e   state_q, state_d;
   logic [PD_W-1:0] pd_q, pd_d;
   logic            src_q, src_d;
   logic            out_full, crd_zero, accept;
   assign arb_req0     = src0_req_valid;
   assign arb_req1     = src1_req_valid;
   assign src0_req_ack = arb_gnt0;
   assign src1_req_ack = arb_gnt1;
   assign out_full     = dma_rd_req_valid & ~dma_rd_req_ready;
   // ready feeds busy combinationally so a draining register can reload in the same cycle
   assign arb_gnt_busy = ~cfg_en | out_full | crd_zero;
   // simultaneous grants are illegal and are not treated as an accept
   assign accept = (arb_gnt0 | arb_gnt1) & ~(arb_gnt0 & arb_gnt1);
   always_comb begin
      state_d = state_q;
      pd_d    = pd_q;
      src_d   = src_q;
      if (accept) begin
         state_d = OUT_FULL;
         pd_d    = arb_gnt1 ? src1_req_pd : src0_req_pd;
         src_d   = arb_gnt1 ? WT_SRC1 : WT_SRC0;
      end else if (state_q == OUT_FULL && dma_rd_req_ready) begin
         state_d = OUT_EMPTY;
      end
   end
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q <= OUT_EMPTY;
         pd_q    <= '0;
         src_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pd_q    <= pd_d;
         src_q   <= src_d;
      end
   end
   assign dma_rd_req_valid = state_q == OUT_FULL;
   assign dma_rd_req_pd    = pd_q;
   assign dma_rd_req_src   = src_q;
   nvdla_cdma_wt_credit_cnt #(.MAX_OUTS(MAX_OUTS), .CRD_W(CRD_W)) u_crd (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .inc_i           (dma_rd_rsp_done),
      .dec_i           (accept),
      .zero_o          (crd_zero),
      .credit_err_o    (credit_err)
   );
`ifdef NVDLA_CDMA_WT_ISSUE_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;
   assign stall_d = ((src0_req_valid | src1_req_valid) & arb_gnt_busy & ~&stall_q) ?
                    stall_q + 32'd1 : stall_q;
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) stall_q <= '0;
      else stall_q <= stall_d;
   end
   assign dbg_stall_cnt = stall_q;
`else
   assign dbg_stall_cnt = '0;
`endif
   a_one_grant: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
      !(arb_gnt0 && arb_gnt1));
endmodule

// File: tb/tb_nvdla_cdma_wt_rd_issue.sv
// tb_nvdla_cdma_wt_rd_issue: directed + random bench with a cycle model of the issue stage.
module tb_nvdla_cdma_wt_rd_issue;
   localparam int PD_W = 79;
   localparam int MAX  = 8;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;
   logic cfg = 1'b1, v0 = 1'b0, v1 = 1'b0, rdy = 1'b1, done = 1'b0;
   logic [PD_W-1:0] pd0 = '0, pd1 = '0;
   logic ncfg = 1'b1, nv0 = 1'b0, nv1 = 1'b0, nrdy = 1'b1, ndone = 1'b0;
   logic [PD_W-1:0] npd0 = '0, npd1 = '0;
   logic ack0, ack1, req0, req1, busy, gnt0, gnt1, dvalid, dsrc, err;
   logic [PD_W-1:0] dpd;
   logic [31:0] stall;
   // strict-priority arbiter stand-in, masked by busy
   assign gnt0 = req0 & ~busy;
   assign gnt1 = req1 & ~req0 & ~busy;
   nvdla_cdma_wt_rd_issue dut (
      .nvdla_core_clk   (clk),
      .nvdla_core_rstn  (rstn),
      .cfg_en           (cfg),
      .src0_req_valid   (v0),
      .src0_req_pd      (pd0),
      .src0_req_ack     (ack0),
      .src1_req_valid   (v1),
      .src1_req_pd      (pd1),
      .src1_req_ack     (ack1),
      .arb_req0         (req0),
      .arb_req1         (req1),
      .arb_gnt0         (gnt0),
      .arb_gnt1         (gnt1),
      .arb_gnt_busy     (busy),
      .dma_rd_req_valid (dvalid),
      .dma_rd_req_ready (rdy),
      .dma_rd_req_pd    (dpd),
      .dma_rd_req_src   (dsrc),
      .dma_rd_rsp_done  (done),
      .credit_err       (err),
      .dbg_stall_cnt    (stall)
   );
   bit m_valid = 0, m_src = 0, m_err = 0, e_ack0 = 0, e_ack1 = 0;
   logic [PD_W-1:0] m_pd = '0;
   int m_credit = MAX;
   longint m_stall = 0;
   int n_chk = 0, n_pass = 0;
   task automatic chk(input string nm, input logic [PD_W-1:0] act, input logic [PD_W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   function automatic logic [PD_W-1:0] rnd();
      return PD_W'({$urandom, $urandom, $urandom});
   endfunction
   // one clock: apply staged inputs after the edge, compare at the falling edge, advance the model
   task automatic step();
      bit bz, a0, a1, acc;
      @(posedge clk);
      #1;
      cfg = ncfg; v0 = nv0; v1 = nv1; rdy = nrdy; done = ndone; pd0 = npd0; pd1 = npd1;
      @(negedge clk);
      bz = !cfg || (m_valid && !rdy) || m_credit == 0;
      a0 = v0 && !bz;
      a1 = v1 && !v0 && !bz;
      acc = a0 || a1;
      chk("busy", PD_W'(busy), PD_W'(bz));
      chk("req0", PD_W'(req0), PD_W'(v0));
      chk("req1", PD_W'(req1), PD_W'(v1));
      chk("ack0", PD_W'(ack0), PD_W'(a0));
      chk("ack1", PD_W'(ack1), PD_W'(a1));
      chk("dma_valid", PD_W'(dvalid), PD_W'(m_valid));
      chk("dma_pd", dpd, m_pd);
      chk("dma_src", PD_W'(dsrc), PD_W'(m_src));
      chk("credit_err", PD_W'(err), PD_W'(m_err));
      chk("stall_cnt", PD_W'(stall), PD_W'(m_stall[31:0]));
      e_ack0 = a0;
      e_ack1 = a1;
`ifdef NVDLA_CDMA_WT_ISSUE_STALL_CNT_EN
      if ((v0 || v1) && bz && m_stall < 64'hFFFF_FFFF) m_stall++;
`endif
      m_valid = acc || (m_valid && !rdy);
      if (acc) begin
         m_pd = a0 ? pd0 : pd1;
         m_src = a1;
      end
      if (done && m_credit == MAX) m_err = 1;
      if (acc && !done) m_credit--;
      else if (done && !acc && m_credit < MAX) m_credit++;
   endtask
   task automatic drain();
      nv0 = 0; nv1 = 0; nrdy = 1; ncfg = 1;
      for (int i = 0; i < 40 && !(m_valid == 0 && m_credit == MAX); i++) begin
         ndone = m_credit < MAX;
         step();
      end
      ndone = 0;
   endtask
   initial begin
      int c0, c1;
      logic [31:0] base;
      repeat (3) @(negedge clk);
      chk("rst_valid", PD_W'(dvalid), '0);
      chk("rst_pd", dpd, '0);
      chk("rst_src", PD_W'(dsrc), '0);
      chk("rst_err", PD_W'(err), '0);
      chk("rst_stall", PD_W'(stall), '0);
      chk("rst_busy", PD_W'(busy), '0);
      rstn = 1'b1;
      // single src0 request
      npd0 = 79'h1000; nv0 = 1; step();
      chk("p1_ack0", PD_W'(ack0), PD_W'(1));
      chk("p1_valid_T", PD_W'(dvalid), '0);
      nv0 = 0; step();
      chk("p1_valid_T1", PD_W'(dvalid), PD_W'(1));
      chk("p1_pd", dpd, 79'h1000);
      chk("p1_src", PD_W'(dsrc), '0);
      // priority: src0 wins while both valid
      drain();
      nv0 = 1; nv1 = 1; npd1 = 79'hB0B; c0 = 0; c1 = 0;
      for (int i = 0; i < 3; i++) begin
         npd0 = 79'h2000 + PD_W'(i);
         step();
         c0 += int'(ack0); c1 += int'(ack1);
      end
      chk("p2_ack0_cnt", PD_W'(c0), PD_W'(3));
      chk("p2_ack1_cnt", PD_W'(c1), '0);
      nv0 = 0; step();
      chk("p2_ack1", PD_W'(ack1), PD_W'(1));
      nv1 = 0; step();
      // back-pressure then back-to-back reload
      drain();
      npd0 = 79'h3000; nv0 = 1; step();
      nv0 = 0; nv1 = 1; npd1 = 79'h3111; nrdy = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("p3_busy", PD_W'(busy), PD_W'(1));
         chk("p3_noack", PD_W'(ack1), '0);
         chk("p3_hold", dpd, 79'h3000);
      end
      nrdy = 1; step();
      chk("p3_reload_ack", PD_W'(ack1), PD_W'(1));
      nv1 = 0; step();
      chk("p3_reload_pd", dpd, 79'h3111);
      chk("p3_reload_src", PD_W'(dsrc), PD_W'(1));
      // credit exhaustion and return
      drain();
      nv0 = 1;
      for (int i = 0; i < 8; i++) begin
         npd0 = 79'h4000 + PD_W'(i);
         step();
      end
      npd0 = 79'h4008; step();
      chk("p4_zero_busy", PD_W'(busy), PD_W'(1));
      chk("p4_zero_noack", PD_W'(ack0), '0);
      ndone = 1; step();
      chk("p4_done_noack", PD_W'(ack0), '0);
      ndone = 0; step();
      chk("p4_after_done_ack", PD_W'(ack0), PD_W'(1));
      npd0 = 79'h4009; ndone = 1; step();
      chk("p4_zero_again", PD_W'(ack0), '0);
      step();
      chk("p4_acc_done_ack", PD_W'(ack0), PD_W'(1));
      npd0 = 79'h400A; ndone = 0; step();
      chk("p4_unchanged_ack", PD_W'(ack0), PD_W'(1));
      npd0 = 79'h400B; step();
      chk("p4_unchanged_busy", PD_W'(busy), PD_W'(1));
      // credit overflow is sticky
      drain();
      ndone = 1; step();
      ndone = 0; step();
      chk("p5_err", PD_W'(err), PD_W'(1));
      repeat (3) step();
      chk("p5_err_sticky", PD_W'(err), PD_W'(1));
      // cfg_en drop while full: drain only
      npd0 = 79'h5000; nv0 = 1; step();
      npd0 = 79'h5001; ncfg = 0; nrdy = 0; step();
      chk("p5_cfg_busy", PD_W'(busy), PD_W'(1));
      chk("p5_cfg_full", PD_W'(dvalid), PD_W'(1));
      nrdy = 1; step();
      chk("p5_cfg_noack", PD_W'(ack0), '0);
      step();
      chk("p5_cfg_drained", PD_W'(dvalid), '0);
      chk("p5_cfg_noack2", PD_W'(ack0), '0);
      // stall counter
      drain();
      npd0 = 79'h6000; nv0 = 1; nrdy = 0; step();
      nv0 = 0; nv1 = 1; base = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (i == 0) base = stall;
      end
      nv1 = 0; nrdy = 1; step();
`ifdef NVDLA_CDMA_WT_ISSUE_STALL_CNT_EN
      chk("p6_stall10", PD_W'(stall - base), PD_W'(10));
`else
      chk("p6_stall0", PD_W'(stall), '0);
`endif
      // random traffic
      drain();
      for (int i = 0; i < 3000; i++) begin
         if (e_ack0) begin nv0 = $urandom_range(0, 1) == 1; npd0 = rnd(); end
         else if (!nv0) begin nv0 = $urandom_range(0, 3) == 0; npd0 = rnd(); end
         if (e_ack1) begin nv1 = $urandom_range(0, 1) == 1; npd1 = rnd(); end
         else if (!nv1) begin nv1 = $urandom_range(0, 3) == 0; npd1 = rnd(); end
         nrdy = $urandom_range(0, 3) != 0;
         ncfg = $urandom_range(0, 15) != 0;
         ndone = (m_credit < MAX) && ($urandom_range(0, 1) == 1);
         step();
      end
      drain();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
